loop_unit: RTL and testbench
============================

Name: loop_unit

Overview:
- Loop-control stage of the Brainfuck core.
- Sits between instruction fetch/decode and the return-address stack (WIDTH-wide, 2^DEPTH_POW deep, synchronous, registered Q).
- Decodes '[' and ']', drives the stack's PUSH/POP/D, consumes its Q, and issues jumps to fetch.
- Also runs the forward skip to the matching ']' when a loop is entered with a zero cell.

Parameters:
WIDTH, 11, program address width; matches stack data width.
DEPTH_POW, 7, log2 of stack depth; stack holds 2^DEPTH_POW entries.
SKIP_W, 8, width of the nesting counter used during forward skip.

Ports:
CLK  in  1  clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
INSN_VALID  in  1  instruction strobe; counts only when READY=1.
INSN  in  8  ASCII opcode; '[' = 8'h5B, ']' = 8'h5D, everything else is "other".
PC  in  WIDTH  address of INSN.
CELL_ZERO  in  1  current data cell == 0; sampled with INSN_VALID.
READY  out  1  block can accept INSN this cycle.
SKIP  out  1  skip in progress; fetch advances, core must not execute INSN.
JUMP  out  1  one-cycle pulse; fetch loads JUMP_ADDR.
JUMP_ADDR  out  WIDTH  jump target.
STK_PUSH  out  1  to stack PUSH.
STK_POP  out  1  to stack POP.
STK_D  out  WIDTH  to stack D; equals PC.
STK_Q  in  WIDTH  from stack Q; valid the cycle after STK_POP.

Behaviour:
- States: IDLE, POPWAIT, SKIPPING.
- Reset (async, RESET_N=0):
  - state IDLE, nesting counter 0, LEVEL 0.
  - READY=1, SKIP=0, JUMP=0, JUMP_ADDR=0, STK_PUSH=0, STK_POP=0.
  - Top level also asserts the stack's synchronous RESET while RESET_N=0.
- Accept condition: INSN_VALID & READY. INSN_VALID while READY=0 is ignored; upstream holds it.
- STK_PUSH and STK_POP are combinational from accept & decode & state. Each is a single-cycle pulse, never both in one cycle. STK_D = PC at all times.
- IDLE, accept '[', CELL_ZERO=0:
  - STK_PUSH=1 (stores address of '['); LEVEL+1; stay IDLE.
- IDLE, accept '[', CELL_ZERO=1:
  - no push; counter <= 1; next state SKIPPING.
- IDLE, accept ']':
  - STK_POP=1; LEVEL-1; latch CELL_ZERO; next state POPWAIT.
- POPWAIT (exactly one cycle):
  - READY=0.
  - If latched CELL_ZERO=0: JUMP=1, JUMP_ADDR=STK_Q.
  - Always returns to IDLE.
  - Latency: ']' accepted at cycle N -> JUMP at N+1 -> READY=1 at N+1's following cycle (N+2).
  - The jumped-to '[' re-executes and re-pushes.
- IDLE, accept other opcode: no action.
- SKIPPING:
  - SKIP=1, READY=1.
  - '[' -> counter+1.
  - ']' -> counter-1. If counter was 1: next state IDLE and SKIP=0 from the next cycle. The closing ']' is consumed, not executed.
  - Other opcodes: ignored.
  - No stack traffic in this state.
- Counter arithmetic is unsigned SKIP_W bits.
- LEVEL is unsigned DEPTH_POW+1 bits, range 0..2^DEPTH_POW.
- JUMP_ADDR holds its last value when JUMP=0.
- Reset mid-operation (any state) aborts immediately. No pending JUMP is issued after reset release.

Optional Feature:
Macro: BF_LOOP_CHECK_EN.
- Defined:
  - Adds output port ERR (1 bit, reset 0, sticky until RESET_N).
  - '[' push at LEVEL == 2^DEPTH_POW: ERR=1, push suppressed, LEVEL unchanged.
  - ']' at LEVEL == 0: ERR=1, pop suppressed, no JUMP, still passes through POPWAIT.
  - Nesting counter increment at all-ones: ERR=1, counter saturates.
- Not defined:
  - No ERR port.
  - Pushes and pops are unconditional; the stack pointer wraps as the stack allows.
  - LEVEL logic may be optimised out.

Test Plan:
1. IDLE, INSN='[', PC=11'h010, CELL_ZERO=0 -> STK_PUSH=1 in the same cycle, STK_D=11'h010; READY stays 1; SKIP=0; no JUMP.
2. After test 1, INSN=']' at PC=11'h020, CELL_ZERO=0 at cycle N:
   - cycle N: STK_POP=1.
   - cycle N+1: READY=0, JUMP=1, JUMP_ADDR=11'h010.
   - cycle N+2: READY=1, JUMP=0.
3. After a push of 11'h030, INSN=']' with CELL_ZERO=1 -> STK_POP=1, POPWAIT one cycle, JUMP never asserted, READY=1 at N+2.
4. '[' with CELL_ZERO=1, then stream "+[-]]>":
   - SKIP=1 from the next cycle.
   - Counter goes 1 -> 2 -> 1 -> 0.
   - SKIP=0 in the cycle after the second ']'; '>' is accepted with SKIP=0.
   - Zero STK_PUSH/STK_POP pulses throughout.
5. With BF_LOOP_CHECK_EN, DEPTH_POW=7:
   - 128 accepted '[' (CELL_ZERO=0): no error.
   - 129th '[': STK_PUSH=0, ERR=1.
   - Subsequent valid traffic: ERR stays 1.
   - After reset, ']' at LEVEL 0: STK_POP=0, no JUMP, ERR=1.
6. RESET_N pulsed low mid-SKIPPING (counter=2) and separately during POPWAIT -> outputs zero asynchronously, READY=1; after release a '[' with CELL_ZERO=0 pushes normally and no stale JUMP appears.

Source files
------------

// File: rtl/loop_unit.sv
// loop_unit: loop-control stage of the Brainfuck core.
// Decodes '[' / ']', drives the return-address stack (PUSH/POP/D), turns the
// popped address into a one-cycle JUMP, and runs the forward skip to the
// matching ']' when a loop is entered with a zero cell.
// Optional build macro: BF_LOOP_CHECK_EN adds a sticky ERR output and guards
// against stack overflow/underflow and nesting-counter overflow.
module loop_unit #(
  parameter int WIDTH     = 11,
  parameter int DEPTH_POW = 7,
  parameter int SKIP_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             INSN_VALID,
  input  logic [7:0]       INSN,
  input  logic [WIDTH-1:0] PC,
  input  logic             CELL_ZERO,
  output logic             READY,
  output logic             SKIP,
  output logic             JUMP,
  output logic [WIDTH-1:0] JUMP_ADDR,
  output logic             STK_PUSH,
  output logic             STK_POP,
  output logic [WIDTH-1:0] STK_D,
  input  logic [WIDTH-1:0] STK_Q
`ifdef BF_LOOP_CHECK_EN
  ,
  output logic             ERR
`endif
);

  localparam logic [7:0]        OP_LB   = 8'h5B;
  localparam logic [7:0]        OP_RB   = 8'h5D;
  localparam logic [SKIP_W-1:0] CNT_ONE = SKIP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POPWAIT,
    S_SKIPPING
  } state_e;

  state_e            state_q, state_d;
  logic [SKIP_W-1:0] cnt_q, cnt_d;        // nesting depth while skipping
  logic              jmp_en_q, jmp_en_d;  // POPWAIT should jump (cell was non-zero)
  logic [WIDTH-1:0]  jaddr_q;             // last issued jump target

  logic accept;
  logic is_lb;
  logic is_rb;
  logic push;
  logic pop;
  logic jump;

  // Guard conditions; constant zero when checking is compiled out so the
  // stack traffic is unconditional and the counter simply wraps.
  logic chk_full;
  logic chk_empty;
  logic chk_sat;

`ifdef BF_LOOP_CHECK_EN
  localparam logic [DEPTH_POW:0] LEVEL_FULL = {1'b1, {DEPTH_POW{1'b0}}};

  logic [DEPTH_POW:0] level_q, level_d;  // current number of stacked '[' addresses
  logic               err_q;
  logic               err_set;

  assign chk_full  = (level_q == LEVEL_FULL);
  assign chk_empty = (level_q == '0);
  assign chk_sat   = &cnt_q;
  assign ERR       = err_q;

  // Track stack occupancy from the pulses actually sent to the stack.
  always_comb begin
    level_d = level_q;
    if (push) begin
      level_d = level_q + 1'b1;
    end else if (pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Occupancy register and sticky error flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  // Stack depth only matters to the occupancy check, which is not built here.
  logic unused_depth_bit;
  assign unused_depth_bit = DEPTH_POW[0];

  assign chk_full  = 1'b0;
  assign chk_empty = 1'b0;
  assign chk_sat   = 1'b0;
`endif

  assign READY  = (state_q != S_POPWAIT);
  assign SKIP   = (state_q == S_SKIPPING);
  assign accept = INSN_VALID & READY;
  assign is_lb  = (INSN == OP_LB);
  assign is_rb  = (INSN == OP_RB);

  // Next-state, counter and stack/jump strobes from state and accepted opcode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jmp_en_d = jmp_en_q;
    push     = 1'b0;
    pop      = 1'b0;
    jump     = 1'b0;
`ifdef BF_LOOP_CHECK_EN
    err_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_lb) begin
            if (CELL_ZERO) begin
              // Loop body is skipped: count this '[' as the first level.
              cnt_d   = CNT_ONE;
              state_d = S_SKIPPING;
            end else if (chk_full) begin
`ifdef BF_LOOP_CHECK_EN
              err_set = 1'b1;
`endif
            end else begin
              push = 1'b1;
            end
          end else if (is_rb) begin
            // POPWAIT is always visited so ']' has a fixed two-cycle cost.
            state_d = S_POPWAIT;
            if (chk_empty) begin
`ifdef BF_LOOP_CHECK_EN
              err_set = 1'b1;
`endif
              jmp_en_d = 1'b0;
            end else begin
              pop      = 1'b1;
              jmp_en_d = ~CELL_ZERO;
            end
          end
        end
      end

      S_POPWAIT: begin
        // Stack Q now holds the address of the matching '['.
        jump    = jmp_en_q;
        state_d = S_IDLE;
      end

      S_SKIPPING: begin
        if (accept) begin
          if (is_lb) begin
            if (chk_sat) begin
`ifdef BF_LOOP_CHECK_EN
              err_set = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (is_rb) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, skip counter and pending-jump flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      jmp_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jmp_en_q <= jmp_en_d;
    end
  end

  // Remember the last target so JUMP_ADDR holds between jumps.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      jaddr_q <= '0;
    end else if (jump) begin
      jaddr_q <= STK_Q;
    end
  end

  assign JUMP      = jump;
  assign JUMP_ADDR = jump ? STK_Q : jaddr_q;
  assign STK_PUSH  = push;
  assign STK_POP   = pop;
  assign STK_D     = PC;

endmodule

// File: tb/tb_loop_unit.sv
// Scoreboard bench for loop_unit: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares. A behavioural return-address
// stack with registered Q sits on the STK_* ports.
// Build with BF_LOOP_CHECK_EN defined to include the error-check vectors.
module tb_loop_unit;

  localparam int W = 11;

  localparam logic [7:0] LB    = 8'h5B;
  localparam logic [7:0] RB    = 8'h5D;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] GT    = 8'h3E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n      = 1'b0;
  logic         insn_valid = 1'b0;
  logic [7:0]   insn       = 8'h00;
  logic [W-1:0] pc         = '0;
  logic         cell_zero  = 1'b0;
  logic         ready, skip, jump, stk_push, stk_pop;
  logic [W-1:0] jump_addr, stk_d;
  logic [W-1:0] stk_q = '0;
`ifdef BF_LOOP_CHECK_EN
  logic         err;
`endif

  loop_unit #(.WIDTH(W), .DEPTH_POW(7), .SKIP_W(8)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .INSN_VALID(insn_valid),
    .INSN      (insn),
    .PC        (pc),
    .CELL_ZERO (cell_zero),
    .READY     (ready),
    .SKIP      (skip),
    .JUMP      (jump),
    .JUMP_ADDR (jump_addr),
    .STK_PUSH  (stk_push),
    .STK_POP   (stk_pop),
    .STK_D     (stk_d),
    .STK_Q     (stk_q)
`ifdef BF_LOOP_CHECK_EN
    ,
    .ERR       (err)
`endif
  );

  // Return-address stack: 128 entries, synchronous reset, registered Q.
  logic [W-1:0] stk_mem [0:127];
  logic [6:0]   sp = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (stk_push) begin
      stk_mem[sp] <= stk_d;
      sp          <= sp + 7'd1;
    end else if (stk_pop) begin
      stk_q <= stk_mem[sp - 7'd1];
      sp    <= sp - 7'd1;
    end
  end

  typedef struct packed {
    logic         ready;
    logic         skip;
    logic         push;
    logic         pop;
    logic         jump;
    logic         err;
    logic [W-1:0] jaddr;
    logic [W-1:0] stkd;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  obs_t  mon_e;
  obs_t  mon_a;
  string mon_t;

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a.ready = ready;
      mon_a.skip  = skip;
      mon_a.push  = stk_push;
      mon_a.pop   = stk_pop;
      mon_a.jump  = jump;
`ifdef BF_LOOP_CHECK_EN
      mon_a.err   = err;
`else
      mon_a.err   = 1'b0;
`endif
      mon_a.jaddr = jump_addr;
      mon_a.stkd  = stk_d;
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL %s: got rdy=%0b skip=%0b push=%0b pop=%0b jump=%0b err=%0b jaddr=%h d=%h, required rdy=%0b skip=%0b push=%0b pop=%0b jump=%0b err=%0b jaddr=%h d=%h",
                 mon_t, mon_a.ready, mon_a.skip, mon_a.push, mon_a.pop, mon_a.jump, mon_a.err, mon_a.jaddr, mon_a.stkd,
                 mon_e.ready, mon_e.skip, mon_e.push, mon_e.pop, mon_e.jump, mon_e.err, mon_e.jaddr, mon_e.stkd);
      end else begin
        $display("vec %s ok (rdy=%0b skip=%0b push=%0b pop=%0b jump=%0b jaddr=%h)",
                 mon_t, mon_a.ready, mon_a.skip, mon_a.push, mon_a.pop, mon_a.jump, mon_a.jaddr);
      end
    end
  end

  // Drive one cycle of inputs just after the clock edge and queue the
  // outputs expected during that cycle (STK_D always mirrors PC).
  task automatic step(input logic rn, input logic v, input logic [7:0] ins,
                      input logic [W-1:0] p, input logic cz,
                      input logic r, input logic s, input logic pu, input logic po,
                      input logic ju, input logic [W-1:0] ja, input logic e,
                      input string tag);
    obs_t x;
    @(posedge clk);
    #1;
    rst_n      = rn;
    insn_valid = v;
    insn       = ins;
    pc         = p;
    cell_zero  = cz;
    x = '{r, s, pu, po, ju, e, ja, p};
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  initial begin
    //    rn v  insn   pc      cz  rdy skip push pop jump jaddr   err
    step(0, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "reset");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "idle");

    // Enter loop with non-zero cell, then close it and jump back.
    step(1, 1, LB,    11'h010, 0,  1,  0,   1,   0,  0,  11'h000, 0, "t1_push");
    step(1, 1, RB,    11'h020, 0,  1,  0,   0,   1,  0,  11'h000, 0, "t2_pop");
    step(1, 0, 8'h00, 11'h000, 0,  0,  0,   0,   0,  1,  11'h010, 0, "t2_jump");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h010, 0, "t2_ready");

    // Loop exit: ']' with zero cell pops but never jumps.
    step(1, 1, LB,    11'h030, 0,  1,  0,   1,   0,  0,  11'h010, 0, "t3_push");
    step(1, 1, RB,    11'h040, 1,  1,  0,   0,   1,  0,  11'h010, 0, "t3_pop");
    step(1, 0, 8'h00, 11'h000, 0,  0,  0,   0,   0,  0,  11'h010, 0, "t3_popwait");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h010, 0, "t3_ready");

    // Forward skip over "+[-]]" then '>' runs normally.
    step(1, 1, LB,    11'h050, 1,  1,  0,   0,   0,  0,  11'h010, 0, "t4_enter");
    step(1, 1, PLUS,  11'h051, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t4_plus");
    step(1, 1, LB,    11'h052, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t4_nest");
    step(1, 1, MINUS, 11'h053, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t4_minus");
    step(1, 1, RB,    11'h054, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t4_close_inner");
    step(1, 1, RB,    11'h055, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t4_close_outer");
    step(1, 1, GT,    11'h056, 0,  1,  0,   0,   0,  0,  11'h010, 0, "t4_gt");

    // Reset while skipping at depth 2.
    step(1, 1, LB,    11'h060, 1,  1,  0,   0,   0,  0,  11'h010, 0, "t6_enter");
    step(1, 1, LB,    11'h061, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t6_nest");
    step(1, 0, 8'h00, 11'h000, 0,  1,  1,   0,   0,  0,  11'h010, 0, "t6_skip_hold");
    step(0, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t6_rst_skip");
    step(1, 1, LB,    11'h070, 0,  1,  0,   1,   0,  0,  11'h000, 0, "t6_push_after");

    // Reset while in POPWAIT: the pending jump must be dropped.
    step(1, 1, RB,    11'h071, 0,  1,  0,   0,   1,  0,  11'h000, 0, "t6_pop");
    step(0, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t6_rst_popwait");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t6_no_stale");
    step(1, 1, LB,    11'h080, 0,  1,  0,   1,   0,  0,  11'h000, 0, "t6_push2");
    step(1, 1, RB,    11'h081, 0,  1,  0,   0,   1,  0,  11'h000, 0, "t6_pop2");
    step(1, 0, 8'h00, 11'h000, 0,  0,  0,   0,   0,  1,  11'h080, 0, "t6_jump2");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h080, 0, "t6_ready2");

`ifdef BF_LOOP_CHECK_EN
    // Fill the 128-entry stack, overflow on the 129th, then underflow.
    step(0, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t5_reset");
    for (int i = 0; i < 128; i++) begin
      step(1, 1, LB, W'(32'h100 + i), 0, 1, 0, 1, 0, 0, 11'h000, 0, $sformatf("t5_push%0d", i));
    end
    step(1, 1, LB,    11'h180, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t5_overflow");
    step(1, 1, RB,    11'h181, 0,  1,  0,   0,   1,  0,  11'h000, 1, "t5_err_pop");
    step(1, 0, 8'h00, 11'h000, 0,  0,  0,   0,   0,  1,  11'h17F, 1, "t5_err_jump");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h17F, 1, "t5_err_sticky");
    step(0, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t5_reset2");
    step(1, 1, RB,    11'h190, 0,  1,  0,   0,   0,  0,  11'h000, 0, "t5_underflow");
    step(1, 0, 8'h00, 11'h000, 0,  0,  0,   0,   0,  0,  11'h000, 1, "t5_uf_popwait");
    step(1, 0, 8'h00, 11'h000, 0,  1,  0,   0,   0,  0,  11'h000, 1, "t5_uf_ready");
`endif

    // Let the monitor consume the last expectation, then confirm it did.
    @(negedge clk);
    #1;
    insn_valid = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
